// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - IF / LS request buses and shared memory port bundled for mem_port_arbiter
interface mem_port_arbiter_if #(
   parameter int XLEN = 64
);
   logic            if_valid;
   logic [XLEN-1:0] if_addr;
   logic            if_ready;
   logic            if_flush;
   logic            if_rvalid;
   logic [XLEN-1:0] if_rdata;

   logic            ls_valid;
   logic [XLEN-1:0] ls_addr;
   logic            ls_wen;
   logic [XLEN-1:0] ls_wdata;
   logic [7:0]      ls_wmask;
   logic            ls_ready;
   logic            ls_rvalid;
   logic [XLEN-1:0] ls_rdata;

   logic            mem_valid;
   logic [XLEN-1:0] mem_addr;
   logic            mem_wen;
   logic [XLEN-1:0] mem_wdata;
   logic [7:0]      mem_wmask;
   logic            mem_ready;
   logic            mem_rvalid;
   logic [XLEN-1:0] mem_rdata;

   // Arbiter side: serves both requesters and masters the memory port
   modport master (
      input  if_valid, if_addr, if_flush,
      output if_ready, if_rvalid, if_rdata,
      input  ls_valid, ls_addr, ls_wen, ls_wdata, ls_wmask,
      output ls_ready, ls_rvalid, ls_rdata,
      output mem_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
      input  mem_ready, mem_rvalid, mem_rdata
   );

   // Environment side: requesters plus the memory
   modport slave (
      output if_valid, if_addr, if_flush,
      input  if_ready, if_rvalid, if_rdata,
      output ls_valid, ls_addr, ls_wen, ls_wdata, ls_wmask,
      input  ls_ready, ls_rvalid, ls_rdata,
      input  mem_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
      output mem_ready, mem_rvalid, mem_rdata
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - single-outstanding arbiter of IF and LS requesters onto one memory port
module mem_port_arbiter #(
   parameter int XLEN       = 64,
   parameter int STARVE_MAX = 4
) (
   input logic                clk,
   input logic                rst,
   mem_port_arbiter_if.master bus
);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP} state_t;

   localparam logic [2:0]      STARVE_LIM = 3'(STARVE_MAX);
   localparam logic [XLEN-1:0] ADDR_MASK  = {{(XLEN-3){1'b1}}, 3'b000};

   state_t          state_q, state_d;
   logic [2:0]      starve_q, starve_d;
   logic            drop_q, drop_d;
   logic            own_if_q, own_if_d;
   logic [XLEN-1:0] req_addr_q, req_addr_d;
   logic            req_wen_q, req_wen_d;
   logic [XLEN-1:0] req_wdata_q, req_wdata_d;
   logic [7:0]      req_wmask_q, req_wmask_d;
   logic [XLEN-1:0] if_rdata_q, if_rdata_d;
   logic [XLEN-1:0] ls_rdata_q, ls_rdata_d;
   logic            if_rvalid_q, if_rvalid_d;
   logic            ls_rvalid_q, ls_rvalid_d;

   logic            if_ready_c;
   logic            ls_ready_c;
   logic            mem_valid_c;
   logic            drop_now;

   // State register; reset aborts any transaction in flight and clears every copy
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         starve_q    <= 3'd0;
         drop_q      <= 1'b0;
         own_if_q    <= 1'b0;
         req_addr_q  <= '0;
         req_wen_q   <= 1'b0;
         req_wdata_q <= '0;
         req_wmask_q <= 8'h00;
         if_rdata_q  <= '0;
         ls_rdata_q  <= '0;
         if_rvalid_q <= 1'b0;
         ls_rvalid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         starve_q    <= starve_d;
         drop_q      <= drop_d;
         own_if_q    <= own_if_d;
         req_addr_q  <= req_addr_d;
         req_wen_q   <= req_wen_d;
         req_wdata_q <= req_wdata_d;
         req_wmask_q <= req_wmask_d;
         if_rdata_q  <= if_rdata_d;
         ls_rdata_q  <= ls_rdata_d;
         if_rvalid_q <= if_rvalid_d;
         ls_rvalid_q <= ls_rvalid_d;
      end
   end

   // Next state: arbitration and request capture in IDLE, memory handshake in REQ, response steering in RESP
   always_comb begin
      state_d     = state_q;
      starve_d    = starve_q;
      drop_d      = drop_q;
      own_if_d    = own_if_q;
      req_addr_d  = req_addr_q;
      req_wen_d   = req_wen_q;
      req_wdata_d = req_wdata_q;
      req_wmask_d = req_wmask_q;
      if_rdata_d  = if_rdata_q;
      ls_rdata_d  = ls_rdata_q;
      if_rvalid_d = 1'b0;
      ls_rvalid_d = 1'b0;
      if_ready_c  = 1'b0;
      ls_ready_c  = 1'b0;
      mem_valid_c = 1'b0;
      drop_now    = drop_q;
      case (state_q)
         S_IDLE: begin
            // LS wins by default; IF is forced through once LS has been granted STARVE_MAX times over it
            if (bus.ls_valid && !(bus.if_valid && starve_q >= STARVE_LIM)) begin
               ls_ready_c  = 1'b1;
               own_if_d    = 1'b0;
               req_addr_d  = bus.ls_addr;
               req_wen_d   = bus.ls_wen;
               req_wdata_d = bus.ls_wdata;
               req_wmask_d = bus.ls_wen ? bus.ls_wmask : 8'h00;
               if (bus.if_valid)
                  starve_d = (starve_q >= STARVE_LIM) ? starve_q : starve_q + 3'd1;
               else
                  starve_d = 3'd0;
               drop_d      = 1'b0;
               state_d     = S_REQ;
            end else if (bus.if_valid) begin
               // A flush arriving with the grant targets older fetches, not this one
               if_ready_c  = 1'b1;
               own_if_d    = 1'b1;
               req_addr_d  = bus.if_addr;
               req_wen_d   = 1'b0;
               req_wdata_d = '0;
               req_wmask_d = 8'h00;
               starve_d    = 3'd0;
               drop_d      = 1'b0;
               state_d     = S_REQ;
            end
         end
         S_REQ: begin
            mem_valid_c = 1'b1;
            if (own_if_q && bus.if_flush)
               drop_d = 1'b1;
            if (bus.mem_ready)
               state_d = S_RESP;
         end
         S_RESP: begin
            // A flush in the completing cycle still discards the fetch
            drop_now = drop_q | (own_if_q & bus.if_flush);
            drop_d   = drop_now;
            if (bus.mem_rvalid) begin
               state_d = S_IDLE;
               drop_d  = 1'b0;
               if (!own_if_q) begin
                  ls_rdata_d  = bus.mem_rdata;
                  ls_rvalid_d = 1'b1;
               end else if (!drop_now) begin
                  if_rdata_d  = bus.mem_rdata;
                  if_rvalid_d = 1'b1;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Readies are gated by rst so an asynchronous reset silences them before any clock edge
   assign bus.if_ready  = if_ready_c & ~rst;
   assign bus.ls_ready  = ls_ready_c & ~rst;
   assign bus.if_rvalid = if_rvalid_q;
   assign bus.ls_rvalid = ls_rvalid_q;
   assign bus.if_rdata  = if_rdata_q;
   assign bus.ls_rdata  = ls_rdata_q;
   assign bus.mem_valid = mem_valid_c;
   assign bus.mem_addr  = req_addr_q & ADDR_MASK;
   assign bus.mem_wen   = req_wen_q;
   assign bus.mem_wdata = req_wdata_q;
   assign bus.mem_wmask = req_wmask_q;

endmodule
